// File: rtl/mode_countdown_timer_if.sv
// Button-control <-> countdown-timer link; master is the start/mode logic, slave is the timer.
// TIMER_PAUSE_EN adds the pause level; all slave outputs are registered, no backpressure.
interface mode_countdown_timer_if;
  logic [1:0]  mode;
  logic        start;
  logic        idle;
`ifdef TIMER_PAUSE_EN
  logic        pause;
`endif
  logic        timerEnd;
  logic        running;
  logic [12:0] secs_left;
  logic [3:0]  min_tens;
  logic [3:0]  min_ones;
  logic [3:0]  sec_tens;
  logic [3:0]  sec_ones;

`ifdef TIMER_PAUSE_EN
  modport master (output mode, start, idle, pause,
                  input  timerEnd, running, secs_left, min_tens, min_ones, sec_tens, sec_ones);
  modport slave  (input  mode, start, idle, pause,
                  output timerEnd, running, secs_left, min_tens, min_ones, sec_tens, sec_ones);
`else
  modport master (output mode, start, idle,
                  input  timerEnd, running, secs_left, min_tens, min_ones, sec_tens, sec_ones);
  modport slave  (input  mode, start, idle,
                  output timerEnd, running, secs_left, min_tens, min_ones, sec_tens, sec_ones);
`endif
endinterface

// File: rtl/mode_countdown_timer.sv
// Per-mode preset countdown (1 s ticks) with binary and mm:ss BCD outputs; TIMER_PAUSE_EN adds pause.
// Latency: preset visible one cycle after the start rise; outputs registered; no backpressure.
module mode_countdown_timer #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int MODE0_SEC     = 60,
  parameter int MODE1_SEC     = 120,
  parameter int MODE2_SEC     = 300,
  parameter int MODE3_SEC     = 600
) (
  input  logic                    clk,
  input  logic                    rst,
  mode_countdown_timer_if.slave   bus
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  // Minutes saturate at 99 so an out-of-range preset still shows a legal display.
  function automatic logic [15:0] to_bcd(input int s);
    int m;
    int r;
    m = s / 60;
    r = s % 60;
    if (m > 99) m = 99;
    return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
  endfunction

  localparam logic [15:0] BCD0 = to_bcd(MODE0_SEC);
  localparam logic [15:0] BCD1 = to_bcd(MODE1_SEC);
  localparam logic [15:0] BCD2 = to_bcd(MODE2_SEC);
  localparam logic [15:0] BCD3 = to_bcd(MODE3_SEC);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  logic            start_q;
  logic [PW-1:0]   presc_q;
  logic [12:0]     secs_q;
  logic [15:0]     bcd_q;
  logic            timer_end_q;
  logic            running_q;

  logic [12:0]     preset_sec_d;
  logic [15:0]     preset_bcd_d;
  logic [15:0]     bcd_dec_d;

  always_comb begin
    preset_sec_d = 13'(MODE0_SEC);
    preset_bcd_d = BCD0;
    case (bus.mode)
      2'd1:    begin preset_sec_d = 13'(MODE1_SEC); preset_bcd_d = BCD1; end
      2'd2:    begin preset_sec_d = 13'(MODE2_SEC); preset_bcd_d = BCD2; end
      2'd3:    begin preset_sec_d = 13'(MODE3_SEC); preset_bcd_d = BCD3; end
      default: begin preset_sec_d = 13'(MODE0_SEC); preset_bcd_d = BCD0; end
    endcase
  end

  // mm:ss borrow chain: ones wrap to 9, seconds tens wrap to 5.
  always_comb begin
    bcd_dec_d = bcd_q;
    if (bcd_q[3:0] != 4'd0) begin
      bcd_dec_d[3:0] = bcd_q[3:0] - 4'd1;
    end else begin
      bcd_dec_d[3:0] = 4'd9;
      if (bcd_q[7:4] != 4'd0) begin
        bcd_dec_d[7:4] = bcd_q[7:4] - 4'd1;
      end else begin
        bcd_dec_d[7:4] = 4'd5;
        if (bcd_q[11:8] != 4'd0) begin
          bcd_dec_d[11:8] = bcd_q[11:8] - 4'd1;
        end else begin
          bcd_dec_d[11:8]  = 4'd9;
          bcd_dec_d[15:12] = bcd_q[15:12] - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      presc_q     <= '0;
      secs_q      <= '0;
      bcd_q       <= '0;
      timer_end_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      start_q <= bus.start;
      case (state_q)
        IDLE: begin
          timer_end_q <= 1'b0;
          if (bus.start && !start_q) begin
            state_q   <= RUN;
            running_q <= 1'b1;
            secs_q    <= preset_sec_d;
            bcd_q     <= preset_bcd_d;
            presc_q   <= '0;
          end
        end
        RUN: begin
          if (!bus.start) begin
            state_q     <= IDLE;
            running_q   <= 1'b0;
            timer_end_q <= 1'b0;
            secs_q      <= '0;
            bcd_q       <= '0;
            presc_q     <= '0;
          end else if (secs_q == 13'd0) begin
            // Zero reached: pulse once, then leave on the cycle after the pulse.
            if (timer_end_q) begin
              state_q     <= DONE;
              running_q   <= 1'b0;
              timer_end_q <= 1'b0;
            end else begin
              timer_end_q <= 1'b1;
            end
`ifdef TIMER_PAUSE_EN
          end else if (bus.pause) begin
            presc_q <= presc_q;
`endif
          end else if (presc_q == PRESC_MAX) begin
            presc_q <= '0;
            if (secs_q == 13'd1) begin
              secs_q      <= '0;
              bcd_q       <= '0;
              timer_end_q <= 1'b1;
            end else begin
              secs_q <= secs_q - 13'd1;
              bcd_q  <= bcd_dec_d;
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        DONE: begin
          state_q     <= IDLE;
          timer_end_q <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          running_q   <= 1'b0;
          timer_end_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.timerEnd  = timer_end_q;
  assign bus.running   = running_q;
  assign bus.secs_left = secs_q;
  assign bus.min_tens  = bcd_q[15:12];
  assign bus.min_ones  = bcd_q[11:8];
  assign bus.sec_tens  = bcd_q[7:4];
  assign bus.sec_ones  = bcd_q[3:0];

endmodule

// File: tb/tb_mode_countdown_timer.sv
// Directed bench: dut_a (4 ticks/s, presets 3/0/5/600) and dut_b (2 ticks/s) share clock and reset.
module tb_mode_countdown_timer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  mode_countdown_timer_if ifa ();
  mode_countdown_timer_if ifb ();

  mode_countdown_timer #(
    .TICKS_PER_SEC(4), .MODE0_SEC(3), .MODE1_SEC(0), .MODE2_SEC(5), .MODE3_SEC(600)
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));

  mode_countdown_timer #(
    .TICKS_PER_SEC(2), .MODE0_SEC(60), .MODE1_SEC(120), .MODE2_SEC(300), .MODE3_SEC(600)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance to cycle n; cycle k is observed 1 time unit after the k-th rising edge.
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  function automatic logic [15:0] dig_a();
    return {ifa.min_tens, ifa.min_ones, ifa.sec_tens, ifa.sec_ones};
  endfunction

  function automatic logic [15:0] dig_b();
    return {ifb.min_tens, ifb.min_ones, ifb.sec_tens, ifb.sec_ones};
  endfunction

  initial begin
    ifa.mode = 2'd0; ifa.start = 1'b0; ifa.idle = 1'b1;
    ifb.mode = 2'd0; ifb.start = 1'b0; ifb.idle = 1'b1;
`ifdef TIMER_PAUSE_EN
    ifa.pause = 1'b0;
    ifb.pause = 1'b0;
`endif
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_running", ifa.running, 0);
    chk("reset_timerEnd", ifa.timerEnd, 0);
    chk("reset_secs", ifa.secs_left, 0);
    chk("reset_digits", dig_a(), 16'h0000);
    rst = 1'b1;
    cyc = 0;

    // Basic mode-0 run: rise at 10, RUN from 11, completion pulse at 23, IDLE at 25.
    goto(10); ifa.mode = 2'd0; ifa.start = 1'b1;
    goto(11);
    chk("run_running", ifa.running, 1);
    chk("run_secs_load", ifa.secs_left, 3);
    chk("run_digits_load", dig_a(), 16'h0003);
    goto(14); chk("run_secs_c14", ifa.secs_left, 3);
    goto(15); chk("run_secs_c15", ifa.secs_left, 2);
    chk("run_digits_c15", dig_a(), 16'h0002);
    goto(19); chk("run_secs_c19", ifa.secs_left, 1);
    goto(22); chk("run_te_c22", ifa.timerEnd, 0);
    goto(23);
    chk("run_te_c23", ifa.timerEnd, 1);
    chk("run_secs_c23", ifa.secs_left, 0);
    chk("run_digits_c23", dig_a(), 16'h0000);
    goto(24);
    chk("run_te_c24", ifa.timerEnd, 0);
    chk("run_running_c24", ifa.running, 0);
    // start still high: no retrigger
    goto(30);
    chk("noretrig_running", ifa.running, 0);
    chk("noretrig_secs", ifa.secs_left, 0);

    // Mode change mid-run is ignored; the next rise picks up mode 2.
    ifa.start = 1'b0;
    goto(31); ifa.start = 1'b1;
    goto(32); chk("mchg_secs_load", ifa.secs_left, 3);
    goto(33); ifa.mode = 2'd2;
    goto(36); chk("mchg_secs_c36", ifa.secs_left, 2);
    goto(43); chk("mchg_te_c43", ifa.timerEnd, 0);
    goto(44); chk("mchg_te_c44", ifa.timerEnd, 1);
    goto(46); ifa.start = 1'b0;
    goto(47); ifa.start = 1'b1;
    goto(48);
    chk("mode2_secs", ifa.secs_left, 5);
    chk("mode2_digits", dig_a(), 16'h0005);
    chk("mode2_running", ifa.running, 1);

    // Abort: start drops at 50, IDLE with cleared outputs at 51, no pulse.
    goto(50); ifa.start = 1'b0;
    goto(51);
    chk("abort_running", ifa.running, 0);
    chk("abort_secs", ifa.secs_left, 0);
    chk("abort_digits", dig_a(), 16'h0000);
    chk("abort_te", ifa.timerEnd, 0);
    goto(52); chk("abort_te_c52", ifa.timerEnd, 0);

    // Abort in the same cycle as a tick wins over the decrement.
    goto(60); ifa.mode = 2'd0; ifa.start = 1'b1;
    goto(64); chk("abtick_secs_c64", ifa.secs_left, 3);
    ifa.start = 1'b0;
    goto(65);
    chk("abtick_secs", ifa.secs_left, 0);
    chk("abtick_running", ifa.running, 0);

    // Zero preset: pulse one cycle after entering RUN, no underflow.
    goto(70); ifa.mode = 2'd1; ifa.start = 1'b1;
    goto(71);
    chk("zero_running", ifa.running, 1);
    chk("zero_te_c71", ifa.timerEnd, 0);
    chk("zero_secs_c71", ifa.secs_left, 0);
    goto(72);
    chk("zero_te_c72", ifa.timerEnd, 1);
    chk("zero_secs_c72", ifa.secs_left, 0);
    goto(73);
    chk("zero_te_c73", ifa.timerEnd, 0);
    chk("zero_running_c73", ifa.running, 0);

    // Asynchronous reset between edges mid-count.
    goto(75); ifa.start = 1'b0;
    goto(80); ifa.mode = 2'd0; ifa.start = 1'b1;
    goto(85); chk("arst_pre_secs", ifa.secs_left, 2);
    goto(86);
    #3 rst = 1'b0;
    #1;
    chk("arst_running", ifa.running, 0);
    chk("arst_secs", ifa.secs_left, 0);
    chk("arst_digits", dig_a(), 16'h0000);
    ifa.start = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b1;

`ifdef TIMER_PAUSE_EN
    // Pause sampled on 7 edges delays every later event by 7 cycles.
    goto(90); ifa.mode = 2'd0; ifa.start = 1'b1;
    goto(93); ifa.pause = 1'b1;
    goto(97);
    chk("pause_running", ifa.running, 1);
    chk("pause_secs_c97", ifa.secs_left, 3);
    goto(100); ifa.pause = 1'b0;
    goto(101); chk("pause_secs_c101", ifa.secs_left, 3);
    goto(102); chk("pause_secs_c102", ifa.secs_left, 2);
    goto(109); chk("pause_te_c109", ifa.timerEnd, 0);
    goto(110); chk("pause_te_c110", ifa.timerEnd, 1);
    goto(112); ifa.start = 1'b0;
`endif

    // Mode-3 preset 600 s with 2 ticks/s: 10:00 -> 09:59 -> 09:58.
    goto(120); ifb.mode = 2'd3; ifb.start = 1'b1;
    goto(121);
    chk("m3_secs_load", ifb.secs_left, 600);
    chk("m3_digits_load", dig_b(), 16'h1000);
    goto(122); chk("m3_secs_c122", ifb.secs_left, 600);
    goto(123);
    chk("m3_secs_tick1", ifb.secs_left, 599);
    chk("m3_digits_tick1", dig_b(), 16'h0959);
    goto(125);
    chk("m3_secs_tick2", ifb.secs_left, 598);
    chk("m3_digits_tick2", dig_b(), 16'h0958);
    chk("m3_te", ifb.timerEnd, 0);
    ifb.start = 1'b0;
    goto(127);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mode_countdown_timer.md
Name: mode_countdown_timer

Overview:
- Countdown timer on the consuming side of the button-control interface.
- Takes the selected `mode[1:0]` and the `start` level from the button control block.
- Runs a per-mode preset countdown at one-second resolution and returns a one-cycle `timerEnd` pulse that moves the start FSM back to idle.
- Also drives the remaining time as binary seconds and as mm:ss BCD digits for the 7-segment display path.

Parameters:
- TICKS_PER_SEC, 100000000, clk cycles per one-second tick. Must be ≥2.
- MODE0_SEC, 60, preset seconds for mode 0. Range 0..5999.
- MODE1_SEC, 120, preset seconds for mode 1.
- MODE2_SEC, 300, preset seconds for mode 2.
- MODE3_SEC, 600, preset seconds for mode 3.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset (0 = reset)
- mode  in  2  selected mode from the mode-select logic
- start  in  1  level; high while the start FSM is in its running state
- idle  in  1  level; high while the start FSM is idle (informational; gates nothing except as stated below)
- timerEnd  out  1  one-cycle pulse at countdown completion
- running  out  1  high in RUN state
- secs_left  out  13  remaining seconds, binary
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  remaining time, BCD mm:ss

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; timerEnd=0; running=0; secs_left=0; all BCD digits=0.
  - Prescaler=0; start_q=0.
- Start edge detection: start_q is start registered each cycle. A start rise is start=1 & start_q=0.

State IDLE:
- On a start rise (ignore idle):
  - Latch mode; load secs_left=MODEx_SEC and load the BCD digits from the same preset.
  - Clear the prescaler; go to RUN on the next edge.
- Secs_left and the digits are valid from cycle N+1, where N is the rise cycle.

State RUN:
- running=1.
- Prescaler counts 0..TICKS_PER_SEC-1. Wrap gives a tick.
- On a tick:
  - secs_left decrements by 1.
  - BCD decrements with borrow: sec_ones 0→9 borrows sec_tens; sec_tens 0→5 borrows min_ones; min_ones 0→9 borrows min_tens.
- A tick with secs_left==1:
  - Set secs_left=0 and digits 00:00.
  - timerEnd=1 for exactly that next cycle; go to DONE.
- First completion occurs exactly MODEx_SEC×TICKS_PER_SEC cycles after entering RUN.
- Preset of 0: RUN detects secs_left==0 on its first cycle, pulses timerEnd, and goes to DONE. No underflow.
- Abort: start=0 while in RUN forces IDLE next cycle; secs_left and digits clear to 0; no timerEnd.
- Abort has priority over a tick in the same cycle.
- Mode changes during RUN are ignored (the latched mode is used).

State DONE:
- timerEnd is already deasserted here; outputs hold 00:00; go to IDLE next cycle.
- A start that is still high does not retrigger; a new rise is required.

Invariants and width rules:
- timerEnd is never high for 2 consecutive cycles.
- secs_left never wraps below 0.
- Presets >5999 are a configuration error; BCD minutes saturate at 99.
- Reset asserted mid-count returns immediately to the reset values.

Optional Feature:
- Macro TIMER_PAUSE_EN.
- When defined:
  - Adds input port `pause` (1 bit).
  - In RUN with pause=1, the prescaler and counters hold and running stays 1.
  - Abort still has priority over pause.
  - Releasing pause resumes from the held prescaler value; no tick is lost or added.
- When undefined: no `pause` port; behaviour is exactly as above.

Test Plan:
- TICKS_PER_SEC=4, MODE0_SEC=3, mode=0, start rises at cycle 10 → running from 11; secs_left 3,2,1,0 at 15,19,23; timerEnd high only at cycle 23; IDLE at 25.
- MODE3_SEC=600, TICKS_PER_SEC=2, mode=3, run one tick → digits go 10:00 → 09:59 and secs_left goes 600 → 599.
- Start drops at cycle 17 of a mode-0 run → IDLE at 18, secs_left=0, timerEnd never pulses.
- Mode changes from 0 to 2 mid-run → countdown still uses the mode-0 preset; re-raising start after completion loads the MODE2_SEC preset.
- MODE1_SEC=0, mode=1, start rise → timerEnd pulses one cycle after entering RUN; secs_left stays 0.
- rst=0 asynchronously mid-count (between clock edges) → all outputs 0 immediately. With TIMER_PAUSE_EN: pause held for 7 cycles → completion delayed by exactly 7 cycles.
